// File: rtl/axi4_byte_writer_if.sv
// AXI4 write-channel bundle (AW, W, B) between the byte writer and the DDR3 slave port.
interface axi4_byte_writer_if;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output awaddr, awlen, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awlen, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi4_byte_writer.sv
// Packs a byte stream into 32-bit little-endian words and writes them to memory as
// AXI4 INCR bursts that never cross a BURST_MAX-word aligned boundary.
module axi4_byte_writer #(
    parameter int BURST_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_size,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        done,
    output logic        err,
    axi4_byte_writer_if.master axi4
);
    localparam int PTR_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    typedef enum logic [2:0] {IDLE, FILL, ADDR, DATA, RESP, DONE} state_t;
    state_t state, state_nxt;

    logic [1:0]       lane;
    logic [31:0]      bytes_left;
    logic [29:0]      waddr;
    logic [31:0]      words_left;
    logic [31:0]      pack_data;
    logic [3:0]       pack_strb;
    logic [35:0]      fifo_mem [BURST_MAX];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic [7:0]       beat_cnt;

    logic [31:0] room;
    logic [31:0] blen;
    logic [33:0] words_sum;
    logic        packer_on;
    logic        byte_hs;
    logic        push;
    logic        pop;
    logic        last_beat;
    logic [31:0] merged_data;
    logic [3:0]  merged_strb;
    logic [35:0] head;

    // Burst length is capped by the distance to the next aligned BURST_MAX-word boundary.
    always_comb begin
        room = 32'(BURST_MAX) - {2'b00, waddr & 30'(BURST_MAX - 1)};
        blen = (words_left < room) ? words_left : room;
    end

    assign words_sum   = {32'd0, cmd_addr[1:0]} + {2'b00, cmd_size} + 34'd3;
    assign packer_on   = (state == FILL) || (state == ADDR) || (state == DATA) || (state == RESP);
    assign byte_ready  = packer_on && (bytes_left != 32'd0) && (fifo_count < CNT_W'(BURST_MAX));
    assign byte_hs     = byte_valid && byte_ready;
    assign push        = byte_hs && ((lane == 2'd3) || (bytes_left == 32'd1));
    assign pop         = (state == DATA) && (fifo_count != '0) && axi4.wready;
    assign last_beat   = ({24'd0, beat_cnt} == (blen - 32'd1));
    assign merged_data = pack_data | ({24'd0, byte_data} << {lane, 3'b000});
    assign merged_strb = pack_strb | (4'b0001 << lane);
    assign head        = fifo_mem[rd_ptr];

    assign axi4.awaddr  = {waddr, 2'b00};
    assign axi4.awlen   = 8'(blen - 32'd1);
    assign axi4.awburst = 2'b01;
    assign axi4.wdata   = head[31:0];
    assign axi4.wstrb   = head[35:32];
    assign axi4.wlast   = last_beat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cmd_ready    = 1'b0;
        done         = 1'b0;
        axi4.awvalid = 1'b0;
        axi4.wvalid  = 1'b0;
        axi4.bready  = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = (cmd_size == 32'd0) ? DONE : FILL;
                end
            end
            FILL: begin
                if ({{(32-CNT_W){1'b0}}, fifo_count} >= blen) begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                axi4.awvalid = 1'b1;
                if (axi4.awready) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                axi4.wvalid = (fifo_count != '0);
                if (pop && last_beat) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                axi4.bready = 1'b1;
                if (axi4.bvalid) begin
                    state_nxt = (words_left == blen) ? DONE : FILL;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Word memory has no reset; only the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {merged_strb, merged_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane       <= 2'd0;
            bytes_left <= 32'd0;
            waddr      <= 30'd0;
            words_left <= 32'd0;
            pack_data  <= 32'd0;
            pack_strb  <= 4'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            beat_cnt   <= 8'd0;
            err        <= 1'b0;
        end else begin
            if ((state == IDLE) && cmd_valid) begin
                lane       <= cmd_addr[1:0];
                bytes_left <= cmd_size;
                waddr      <= cmd_addr[31:2];
                words_left <= words_sum[33:2];
                pack_data  <= 32'd0;
                pack_strb  <= 4'd0;
                err        <= 1'b0;
            end
            if (byte_hs) begin
                lane       <= lane + 2'd1;
                bytes_left <= bytes_left - 32'd1;
                pack_data  <= push ? 32'd0 : merged_data;
                pack_strb  <= push ? 4'd0 : merged_strb;
            end
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(BURST_MAX - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= (rd_ptr == PTR_W'(BURST_MAX - 1)) ? '0 : rd_ptr + 1'b1;
                beat_cnt <= last_beat ? 8'd0 : beat_cnt + 8'd1;
            end
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            if ((state == RESP) && axi4.bvalid) begin
                err        <= err | (axi4.bresp != 2'b00);
                waddr      <= waddr + blen[29:0];
                words_left <= words_left - blen;
            end
        end
    end
endmodule
